// File: rtl/riscv_ifetch_if.sv
// ----------------------------------------------------------------------------
// riscv_ifetch_if
// Purpose : bundles the signals between the instruction-fetch stage and its
//           neighbours (PC stage, instruction memory, decode stage).
// Signals :
//   fetch_pc       PC stage  -> fetch   current PC
//   redirect       PC stage  -> fetch   non-sequential PC change, flushes fetch
//   pc_advance     fetch     -> PC stage PC may step this cycle
//   imem_req_*     fetch    <-> memory  request channel (valid/ready, addr)
//   imem_rsp_*     memory    -> fetch   response (valid, data), no backpressure
//   id_*           fetch    <-> decode  instruction entry (valid/ready + payload)
//
// Handshake semantics: a transfer happens on a rising clock edge where both
// valid and ready are 1. Valid never depends on ready within the same cycle;
// ready may depend on valid. Payload is only meaningful while valid is 1.
// The response channel has no ready: the fetch stage always accepts it.
//
// Modports: master = the fetch stage, slave = the surrounding pipeline/memory.
// ----------------------------------------------------------------------------
interface riscv_ifetch_if #(
    parameter int WORD_LENGTH = 32
);
    logic [WORD_LENGTH-1:0] fetch_pc;
    logic                   redirect;
    logic                   pc_advance;
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [WORD_LENGTH-1:0] imem_req_addr;
    logic                   imem_rsp_valid;
    logic [WORD_LENGTH-1:0] imem_rsp_data;
    logic                   id_valid;
    logic                   id_ready;
    logic [WORD_LENGTH-1:0] id_insn;
    logic [WORD_LENGTH-1:0] id_pc;
    logic [WORD_LENGTH-1:0] id_pc_plus4;
    logic                   id_misaligned;

    modport master (
        input  fetch_pc, redirect, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, id_ready,
        output pc_advance, imem_req_valid, imem_req_addr, id_valid,
               id_insn, id_pc, id_pc_plus4, id_misaligned
    );

    modport slave (
        output fetch_pc, redirect, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, id_ready,
        input  pc_advance, imem_req_valid, imem_req_addr, id_valid,
               id_insn, id_pc, id_pc_plus4, id_misaligned
    );
endinterface

// File: rtl/riscv_ifetch.sv
// ----------------------------------------------------------------------------
// riscv_ifetch
// Purpose : RISC-V instruction fetch stage. Issues at most one instruction
//           memory request at a time, buffers fetched instructions in a small
//           in-order FIFO for the decode stage, turns misaligned PCs into NOP
//           entries flagged as misaligned, and flushes on redirect.
// Ports   :
//   clk          in   rising-edge clock
//   x_reset      in   synchronous active-low reset
//   bus          if   riscv_ifetch_if.master (PC, memory and decode signals)
//   o_dbg_state  out  current FSM state (REQ=0, WAIT=1, DRAIN=2)
// Parameters:
//   WORD_LENGTH  address / instruction width
//   FIFO_DEPTH   fetched-instruction buffer depth, 2 or 4
//   NOP_INSN     instruction presented when no valid instruction exists
// ----------------------------------------------------------------------------
module riscv_ifetch #(
    parameter int                     WORD_LENGTH = 32,
    parameter int                     FIFO_DEPTH  = 2,
    parameter logic [WORD_LENGTH-1:0] NOP_INSN    = WORD_LENGTH'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             x_reset,
    riscv_ifetch_if.master   bus,
    output logic [1:0]       o_dbg_state
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        REQ   = 2'd0,  // ready to issue a request or push a misaligned NOP
        WAIT  = 2'd1,  // one request outstanding, response will be pushed
        DRAIN = 2'd2   // one request outstanding, response will be discarded
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [WORD_LENGTH-1:0] r_req_pc;
    logic [CW-1:0]          r_count;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          r_wr_ptr;
    logic [WORD_LENGTH-1:0] r_fifo_pc   [FIFO_DEPTH];
    logic [WORD_LENGTH-1:0] r_fifo_insn [FIFO_DEPTH];
    logic                   r_fifo_mis  [FIFO_DEPTH];

    logic                   w_aligned;
    logic                   w_has_credit;
    logic                   w_req_valid;
    logic                   w_req_fire;
    logic                   w_pc_advance;
    logic                   w_push;
    logic                   w_pop;
    logic [WORD_LENGTH-1:0] w_push_pc;
    logic [WORD_LENGTH-1:0] w_push_insn;
    logic                   w_push_mis;
    logic                   w_id_valid;
    logic [WORD_LENGTH-1:0] w_head_pc;

    assign w_aligned = (bus.fetch_pc[1:0] == 2'b00);

    // While a request is in flight its response needs a slot, so WAIT counts
    // as one reserved entry. Requests are only issued from REQ, but keeping
    // the reservation explicit makes the overflow argument local.
    assign w_has_credit = (r_count + CW'(r_state == WAIT)) < CW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_req_valid  = 1'b0;
        w_pc_advance = 1'b0;
        w_push       = 1'b0;
        w_push_pc    = r_req_pc;
        w_push_insn  = bus.imem_rsp_data;
        w_push_mis   = 1'b0;

        case (r_state)
            REQ: begin
                if (!bus.redirect && w_has_credit) begin
                    if (w_aligned) begin
                        w_req_valid = 1'b1;
                        if (bus.imem_req_ready) begin
                            w_pc_advance = 1'b1;
                            w_next_state = WAIT;
                        end
                    end else begin
                        // Misaligned PC: never reaches memory, decode sees a
                        // flagged NOP and handles the exception.
                        w_push       = 1'b1;
                        w_push_pc    = bus.fetch_pc;
                        w_push_insn  = NOP_INSN;
                        w_push_mis   = 1'b1;
                        w_pc_advance = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (bus.redirect) begin
                    // A response in the redirect cycle is the stale one;
                    // drop it. Otherwise wait for it in DRAIN.
                    w_next_state = bus.imem_rsp_valid ? REQ : DRAIN;
                end else if (bus.imem_rsp_valid) begin
                    w_push       = 1'b1;
                    w_next_state = REQ;
                end
            end
            DRAIN: begin
                // The arriving response is the single outstanding one, so it
                // ends DRAIN even if another redirect coincides; a redirect
                // with no response leaves the state unchanged.
                if (bus.imem_rsp_valid) begin
                    w_next_state = REQ;
                end
            end
            default: begin
                w_next_state = REQ;
            end
        endcase

        if (!x_reset) begin
            w_next_state = REQ;
            w_req_valid  = 1'b0;
            w_pc_advance = 1'b0;
            w_push       = 1'b0;
        end
    end

    assign w_req_fire = w_req_valid && bus.imem_req_ready;
    assign w_id_valid = (r_count != '0);
    assign w_pop      = w_id_valid && bus.id_ready && !bus.redirect;

    // ------------------------------------------------------------------
    // State, request PC and FIFO bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!x_reset) begin
            r_state  <= REQ;
            r_req_pc <= '0;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_req_fire) begin
                r_req_pc <= bus.fetch_pc;
            end
            if (bus.redirect) begin
                // Flush wins over any push/pop requested this cycle.
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    // Storage needs no reset: entries are only visible while count != 0.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= w_push_pc;
            r_fifo_insn[r_wr_ptr] <= w_push_insn;
            r_fifo_mis[r_wr_ptr]  <= w_push_mis;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_head_pc = w_id_valid ? r_fifo_pc[r_rd_ptr] : '0;

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = bus.fetch_pc;
    assign bus.pc_advance     = w_pc_advance;
    assign bus.id_valid       = w_id_valid;
    assign bus.id_insn        = w_id_valid ? r_fifo_insn[r_rd_ptr] : NOP_INSN;
    assign bus.id_pc          = w_head_pc;
    assign bus.id_pc_plus4    = w_head_pc + WORD_LENGTH'(4);
    assign bus.id_misaligned  = w_id_valid ? r_fifo_mis[r_rd_ptr] : 1'b0;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_riscv_ifetch.sv
module tb_riscv_ifetch;

    localparam int          W   = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic x_reset;

    // ---------------- per-DUT stimulus and observation (0: depth 2, 1: depth 4)
    logic [W-1:0] fetch_pc  [2];
    logic         redirect  [2];
    logic         req_ready [2];
    logic         rsp_valid [2];
    logic [W-1:0] rsp_data  [2];
    logic         id_ready  [2];

    wire          pc_adv    [2];
    wire          req_valid [2];
    wire          id_valid  [2];
    wire          id_mis    [2];
    wire [W-1:0]  req_addr  [2];
    wire [W-1:0]  id_insn   [2];
    wire [W-1:0]  id_pc     [2];
    wire [W-1:0]  id_pc4    [2];
    wire [1:0]    dbg       [2];

    riscv_ifetch_if #(.WORD_LENGTH(W)) bus0 ();
    riscv_ifetch_if #(.WORD_LENGTH(W)) bus1 ();

    assign bus0.fetch_pc = fetch_pc[0];        assign bus1.fetch_pc = fetch_pc[1];
    assign bus0.redirect = redirect[0];        assign bus1.redirect = redirect[1];
    assign bus0.imem_req_ready = req_ready[0]; assign bus1.imem_req_ready = req_ready[1];
    assign bus0.imem_rsp_valid = rsp_valid[0]; assign bus1.imem_rsp_valid = rsp_valid[1];
    assign bus0.imem_rsp_data = rsp_data[0];   assign bus1.imem_rsp_data = rsp_data[1];
    assign bus0.id_ready = id_ready[0];        assign bus1.id_ready = id_ready[1];

    assign pc_adv[0] = bus0.pc_advance;        assign pc_adv[1] = bus1.pc_advance;
    assign req_valid[0] = bus0.imem_req_valid; assign req_valid[1] = bus1.imem_req_valid;
    assign req_addr[0] = bus0.imem_req_addr;   assign req_addr[1] = bus1.imem_req_addr;
    assign id_valid[0] = bus0.id_valid;        assign id_valid[1] = bus1.id_valid;
    assign id_insn[0] = bus0.id_insn;          assign id_insn[1] = bus1.id_insn;
    assign id_pc[0] = bus0.id_pc;              assign id_pc[1] = bus1.id_pc;
    assign id_pc4[0] = bus0.id_pc_plus4;       assign id_pc4[1] = bus1.id_pc_plus4;
    assign id_mis[0] = bus0.id_misaligned;     assign id_mis[1] = bus1.id_misaligned;

    riscv_ifetch #(.WORD_LENGTH(W), .FIFO_DEPTH(2), .NOP_INSN(NOP)) u_dut2 (
        .clk(clk), .x_reset(x_reset), .bus(bus0), .o_dbg_state(dbg[0])
    );
    riscv_ifetch #(.WORD_LENGTH(W), .FIFO_DEPTH(4), .NOP_INSN(NOP)) u_dut4 (
        .clk(clk), .x_reset(x_reset), .bus(bus1), .o_dbg_state(dbg[1])
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are changed just after the falling edge; outputs sampled #1 later.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int d);
        fetch_pc[d]  = '0;
        redirect[d]  = 1'b0;
        req_ready[d] = 1'b0;
        rsp_valid[d] = 1'b0;
        rsp_data[d]  = '0;
        id_ready[d]  = 1'b0;
    endtask

    task automatic do_reset();
        x_reset = 1'b0;
        idle(0);
        idle(1);
        step();
        step();
        x_reset = 1'b1;
    endtask

    task automatic chk_empty(input int d, input string tag);
        chk1({tag, "_id_valid"}, id_valid[d], 1'b0);
        chk({tag, "_id_insn"}, id_insn[d], NOP);
        chk({tag, "_id_pc"}, id_pc[d], 32'h0);
        chk({tag, "_id_pc4"}, id_pc4[d], 32'h4);
        chk1({tag, "_id_mis"}, id_mis[d], 1'b0);
    endtask

    // One aligned fetch: handshake cycle, then a one-cycle response.
    task automatic fetch_one(input int d, input logic [31:0] pc, input logic [31:0] data);
        fetch_pc[d]  = pc;
        req_ready[d] = 1'b1;
        #1;
        chk1("fo_req_valid", req_valid[d], 1'b1);
        chk1("fo_adv", pc_adv[d], 1'b1);
        chk("fo_req_addr", req_addr[d], pc);
        step();
        req_ready[d] = 1'b0;
        rsp_valid[d] = 1'b1;
        rsp_data[d]  = data;
        #1;
        chk1("fo_adv_wait", pc_adv[d], 1'b0);
        step();
        rsp_valid[d] = 1'b0;
    endtask

    // ---------------- single-transaction vector table ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        redir;
        logic        exp_req;
        logic        exp_adv;
        logic        exp_valid;
        logic [31:0] exp_insn;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc4;
        logic        exp_mis;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];
    vec_t v;

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        mis;
    } ent_t;

    ent_t        mq[$];     // entries decode will see, oldest first
    bit          m_busy;    // a memory request is in flight
    bit          m_drop;    // the in-flight response must be thrown away
    logic [31:0] m_req_pc;

    task automatic run_random(input int d, input int depth, input int cycles);
        ent_t        h;
        logic [31:0] tmp;
        bit          room, al, e_req, e_mis, e_adv, e_valid, pop;
        do_reset();
        mq.delete();
        m_busy = 0;
        m_drop = 0;
        m_req_pc = '0;
        for (int c = 0; c < cycles; c++) begin
            tmp = $urandom;
            if ($urandom_range(0, 7) == 0) tmp = tmp | 32'h1;
            else                           tmp = tmp & 32'hFFFF_FFFC;
            fetch_pc[d]  = tmp;
            redirect[d]  = ($urandom_range(0, 15) == 0);
            req_ready[d] = ($urandom_range(0, 1) == 1);
            rsp_valid[d] = m_busy && ($urandom_range(0, 2) == 0);
            rsp_data[d]  = $urandom;
            id_ready[d]  = ($urandom_range(0, 2) == 0);
            #1;
            e_valid = (mq.size() != 0);
            if (e_valid) h = mq[0];
            else         h = '{pc: 32'h0, insn: NOP, mis: 1'b0};
            room  = (mq.size() < depth);
            al    = (tmp[1:0] == 2'b00);
            e_req = !m_busy && !redirect[d] && al && room;
            e_mis = !m_busy && !redirect[d] && !al && room;
            e_adv = (e_req && req_ready[d]) || e_mis;
            chk1("rnd_req_valid", req_valid[d], e_req);
            chk1("rnd_adv", pc_adv[d], e_adv);
            chk("rnd_req_addr", req_addr[d], tmp);
            chk1("rnd_id_valid", id_valid[d], e_valid);
            chk("rnd_id_insn", id_insn[d], h.insn);
            chk("rnd_id_pc", id_pc[d], h.pc);
            chk("rnd_id_pc4", id_pc4[d], h.pc + 32'd4);
            chk1("rnd_id_mis", id_mis[d], h.mis);
            // advance the model across the coming edge
            if (redirect[d]) begin
                mq.delete();
                if (m_busy) begin
                    if (rsp_valid[d]) begin
                        m_busy = 0;
                        m_drop = 0;
                    end else begin
                        m_drop = 1;
                    end
                end
            end else begin
                pop = e_valid && id_ready[d];
                if (pop) void'(mq.pop_front());
                if (!m_busy) begin
                    if (e_req && req_ready[d]) begin
                        m_busy   = 1;
                        m_drop   = 0;
                        m_req_pc = tmp;
                    end else if (e_mis) begin
                        mq.push_back('{pc: tmp, insn: NOP, mis: 1'b1});
                    end
                end else if (rsp_valid[d]) begin
                    if (!m_drop) mq.push_back('{pc: m_req_pc, insn: rsp_data[d], mis: 1'b0});
                    m_busy = 0;
                    m_drop = 0;
                end
            end
            step();
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] wdata;

        vecs[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0050_0093, 32'h0000_0000, 32'h0000_0004, 1'b0};
        vecs[1] = '{32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
        vecs[2] = '{32'h0000_0006, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b1, 1'b1, NOP,           32'h0000_0006, 32'h0000_000A, 1'b1};
        vecs[3] = '{32'h0000_0001, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b1, 1'b1, NOP,           32'h0000_0001, 32'h0000_0005, 1'b1};
        vecs[4] = '{32'h0000_0100, 32'hBBBB_BBBB, 1'b1, 1'b0, 1'b0, 1'b0, NOP,           32'h0000_0000, 32'h0000_0004, 1'b0};
        vecs[5] = '{32'h0000_0007, 32'hBBBB_BBBB, 1'b1, 1'b0, 1'b0, 1'b0, NOP,           32'h0000_0000, 32'h0000_0004, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h8000_0000, 32'h8000_0004, 1'b0};

        // Reset state, and request/advance held low while reset is asserted.
        x_reset = 1'b0;
        idle(0);
        idle(1);
        @(negedge clk);
        req_ready[0] = 1'b1;
        #1;
        chk1("rst_req_valid", req_valid[0], 1'b0);
        chk1("rst_adv", pc_adv[0], 1'b0);
        step();
        x_reset = 1'b1;
        req_ready[0] = 1'b0;
        #1;
        chk_empty(0, "rst0");
        chk_empty(1, "rst1");
        chk("rst_state", {30'd0, dbg[0]}, 32'd0);
        chk1("rst_req_after", req_valid[0], 1'b1);

        // Table: one transaction per vector from a fresh reset.
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            do_reset();
            fetch_pc[0]  = v.pc;
            redirect[0]  = v.redir;
            req_ready[0] = 1'b1;
            #1;
            chk1("vec_req_valid", req_valid[0], v.exp_req);
            chk1("vec_adv", pc_adv[0], v.exp_adv);
            chk("vec_req_addr", req_addr[0], v.pc);
            step();
            redirect[0]  = 1'b0;
            req_ready[0] = 1'b0;
            fetch_pc[0]  = 32'h0;
            rsp_valid[0] = v.exp_req;
            rsp_data[0]  = v.data;
            #1;
            chk1("vec_adv_next", pc_adv[0], 1'b0);
            step();
            rsp_valid[0] = 1'b0;
            #1;
            chk1("vec_id_valid", id_valid[0], v.exp_valid);
            chk("vec_id_insn", id_insn[0], v.exp_insn);
            chk("vec_id_pc", id_pc[0], v.exp_pc);
            chk("vec_id_pc4", id_pc4[0], v.exp_pc4);
            chk1("vec_id_mis", id_mis[0], v.exp_mis);
        end

        // Backpressure with depth 2: two entries block further requests.
        do_reset();
        fetch_one(0, 32'h0, 32'h0000_00A0);
        fetch_one(0, 32'h4, 32'h0000_00A4);
        fetch_pc[0]  = 32'h8;
        req_ready[0] = 1'b1;
        #1;
        chk1("bp_req_valid_full", req_valid[0], 1'b0);
        chk1("bp_adv_full", pc_adv[0], 1'b0);
        chk("bp_head_pc", id_pc[0], 32'h0);
        chk("bp_head_insn", id_insn[0], 32'h0000_00A0);
        id_ready[0] = 1'b1;
        step();
        id_ready[0] = 1'b0;
        #1;
        chk1("bp_req_valid_pop", req_valid[0], 1'b1);
        chk1("bp_adv_pop", pc_adv[0], 1'b1);
        chk("bp_req_addr", req_addr[0], 32'h8);
        chk("bp_head_pc2", id_pc[0], 32'h4);
        chk("bp_head_insn2", id_insn[0], 32'h0000_00A4);

        // Redirect while waiting: late response dropped, FIFO flushed.
        do_reset();
        fetch_one(0, 32'h8, 32'h0000_0011);
        fetch_pc[0]  = 32'h10;
        req_ready[0] = 1'b1;
        #1;
        chk1("fl_req_valid", req_valid[0], 1'b1);
        step();
        req_ready[0] = 1'b0;
        redirect[0]  = 1'b1;
        fetch_pc[0]  = 32'h100;
        #1;
        chk1("fl_adv_redirect", pc_adv[0], 1'b0);
        step();
        redirect[0] = 1'b0;
        #1;
        chk("fl_state_drain", {30'd0, dbg[0]}, 32'd2);
        chk1("fl_req_drain", req_valid[0], 1'b0);
        chk1("fl_id_valid_flushed", id_valid[0], 1'b0);
        step();
        rsp_valid[0] = 1'b1;
        rsp_data[0]  = 32'hDEAD_BEEF;
        step();
        rsp_valid[0] = 1'b0;
        req_ready[0] = 1'b1;
        #1;
        chk1("fl_id_valid_after", id_valid[0], 1'b0);
        chk1("fl_req_valid_new", req_valid[0], 1'b1);
        chk("fl_req_addr_new", req_addr[0], 32'h100);
        step();
        req_ready[0] = 1'b0;
        rsp_valid[0] = 1'b1;
        rsp_data[0]  = 32'h0000_0022;
        step();
        rsp_valid[0] = 1'b0;
        #1;
        chk("fl_new_pc", id_pc[0], 32'h100);
        chk("fl_new_insn", id_insn[0], 32'h0000_0022);

        // Redirect coincident with response and a pop request.
        do_reset();
        fetch_one(0, 32'h20, 32'h0000_0033);
        fetch_pc[0]  = 32'h24;
        req_ready[0] = 1'b1;
        step();
        req_ready[0] = 1'b0;
        rsp_valid[0] = 1'b1;
        rsp_data[0]  = 32'h0000_0044;
        redirect[0]  = 1'b1;
        id_ready[0]  = 1'b1;
        #1;
        chk1("co_adv", pc_adv[0], 1'b0);
        step();
        rsp_valid[0] = 1'b0;
        redirect[0]  = 1'b0;
        id_ready[0]  = 1'b0;
        #1;
        chk("co_state", {30'd0, dbg[0]}, 32'd0);
        chk1("co_id_valid", id_valid[0], 1'b0);
        chk1("co_req_valid", req_valid[0], 1'b1);

        // Reset while a request is outstanding; response right after is ignored.
        do_reset();
        fetch_pc[0]  = 32'h30;
        req_ready[0] = 1'b1;
        step();
        req_ready[0] = 1'b0;
        x_reset = 1'b0;
        step();
        x_reset = 1'b1;
        fetch_pc[0]  = 32'h40;
        rsp_valid[0] = 1'b1;
        rsp_data[0]  = 32'h0000_0BAD;
        #1;
        chk("rs_state", {30'd0, dbg[0]}, 32'd0);
        chk1("rs_req_valid", req_valid[0], 1'b1);
        step();
        rsp_valid[0] = 1'b0;
        #1;
        chk1("rs_id_valid", id_valid[0], 1'b0);

        // Depth 4: ten push/pop pairs across pointer wrap.
        do_reset();
        id_ready[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wdata = $urandom;
            fetch_one(1, 32'h40 + 32'(i) * 32'd4, wdata);
            #1;
            chk1("wr_id_valid", id_valid[1], 1'b1);
            chk("wr_id_pc", id_pc[1], 32'h40 + 32'(i) * 32'd4);
            chk("wr_id_insn", id_insn[1], wdata);
        end

        // Randomized traffic against the reference model, both depths.
        run_random(0, 2, 1500);
        run_random(1, 4, 1500);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
